// File: rtl/truth_table_capture.sv
// truth_table_capture
//   Sweeps all 128 input vectors of a 7-input Boolean function under test
//   (FUT), samples its output after DUT_LATENCY+1 settle cycles per vector,
//   assembles the 128-bit truth table (bit i = f(i)) and offers it on a
//   valid/ready handshake.
//
//   Optional build macro: TTC_GOLDEN_CHECK_EN
//     Adds golden/mismatch/first_bad_idx ports that compare each sample
//     against an expected table and record the first differing index.
//     Without the macro those ports and their logic are absent; all other
//     behaviour is identical.

module truth_table_capture #(
  parameter int DUT_LATENCY = 0,
  parameter int NUM_INPUTS  = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [6:0]   x_drv,
  input  logic         fut_out,
  output logic         busy,
  output logic [127:0] table_out,
  output logic         table_valid,
  input  logic         table_ready
`ifdef TTC_GOLDEN_CHECK_EN
  ,
  input  logic [127:0] golden,
  output logic         mismatch,
  output logic [6:0]   first_bad_idx
`endif
);

  // Elaboration guards: the sweep is hard-wired to 7 inputs / 128 entries
  // and the settle counter is 4 bits wide.
  if (NUM_INPUTS != 7) begin : g_bad_num_inputs
    $error("truth_table_capture: NUM_INPUTS must be 7");
  end
  if (DUT_LATENCY < 0 || DUT_LATENCY > 15) begin : g_bad_latency
    $error("truth_table_capture: DUT_LATENCY must be in 0..15");
  end

  localparam logic [3:0] LAT      = 4'(DUT_LATENCY);
  localparam logic [6:0] LAST_IDX = 7'd127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e         state_q;
  logic [6:0]     idx_q;      // current vector; drives x_drv directly
  logic [3:0]     wcnt_q;     // settle-cycle counter
  logic           busy_q;
  logic           valid_q;
  logic [127:0]   table_q;
  logic [127:0]   table_d;

`ifdef TTC_GOLDEN_CHECK_EN
  logic           mismatch_q;
  logic [6:0]     first_bad_q;
  logic           bad_d;
`endif

  // Next table value: current table with the sample for idx_q inserted.
  always_comb begin
    // NOTE: assign a full default first so every path writes table_d and no latch is inferred.
    table_d        = table_q;
    table_d[idx_q] = fut_out;
  end

`ifdef TTC_GOLDEN_CHECK_EN
  // A sample disagrees with the expected table at the current index.
  assign bad_d = (fut_out != golden[idx_q]);
`endif

  // Sweep FSM: settle, sample, advance; hold the table until handshake.
  always_ff @(posedge clk) begin
    // NOTE: the whole table is a plain register bank, so it takes the synchronous reset like any other state.
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      table_q     <= '0;
`ifdef TTC_GOLDEN_CHECK_EN
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q       <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b1;
            table_q     <= '0;
`ifdef TTC_GOLDEN_CHECK_EN
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
`endif
            state_q     <= SETTLE;
          end
        end

        SETTLE: begin
          if (wcnt_q == LAT) begin
            state_q <= SAMPLE;
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end

        SAMPLE: begin
          table_q <= table_d;
`ifdef TTC_GOLDEN_CHECK_EN
          // Only the first mismatch of a sweep records its index.
          if (bad_d && !mismatch_q) begin
            mismatch_q  <= 1'b1;
            first_bad_q <= idx_q;
          end
`endif
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            idx_q   <= idx_q + 7'd1;
            wcnt_q  <= '0;
            state_q <= SETTLE;
          end
        end

        HOLD: begin
          // start is deliberately not looked at here, even on the handshake cycle.
          if (table_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_drv       = idx_q;
  assign busy        = busy_q;
  assign table_out   = table_q;
  assign table_valid = valid_q;
`ifdef TTC_GOLDEN_CHECK_EN
  assign mismatch      = mismatch_q;
  assign first_bad_idx = first_bad_q;
`endif

endmodule
